// File: rtl/rect_renderer_multi.sv
// Multi-slot rectangle overlay for a daisy-chained pixel/program stream.
// Double-buffered slot registers (shadow -> active on commit), fixed 2-cycle pipeline.
module rect_renderer_multi #(
  parameter int X_W       = 11,
  parameter int Y_W       = 12,
  parameter int COL_W     = 12,
  parameter int NUM_RECTS = 4,
  parameter int BORDER    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             program_in,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [COL_W-1:0] data_in,
  output logic             program_out,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] data_out
);

  localparam int SLOT_W = Y_W - 3;
  localparam int XC_W   = (COL_W > X_W) ? COL_W : X_W;
  localparam int EXT_W  = (XC_W > Y_W) ? XC_W : Y_W;
  localparam logic [X_W:0] BX = (X_W+1)'(BORDER);
  localparam logic [Y_W:0] BY = (Y_W+1)'(BORDER);

  logic [X_W-1:0]   sh_x_q   [NUM_RECTS];
  logic [Y_W-1:0]   sh_y_q   [NUM_RECTS];
  logic [X_W-1:0]   sh_w_q   [NUM_RECTS];
  logic [Y_W-1:0]   sh_h_q   [NUM_RECTS];
  logic [COL_W-1:0] sh_col_q [NUM_RECTS];
  logic [1:0]       sh_ctl_q [NUM_RECTS];
  logic [X_W-1:0]   ac_x_q   [NUM_RECTS];
  logic [Y_W-1:0]   ac_y_q   [NUM_RECTS];
  logic [X_W-1:0]   ac_w_q   [NUM_RECTS];
  logic [Y_W-1:0]   ac_h_q   [NUM_RECTS];
  logic [COL_W-1:0] ac_col_q [NUM_RECTS];
  logic [1:0]       ac_ctl_q [NUM_RECTS];

  logic [EXT_W-1:0]  data_ext;
  logic              claim;
  logic [SLOT_W-1:0] slot_sel;
  logic [2:0]        reg_sel;

  assign data_ext = EXT_W'(data_in);
  assign claim    = program_in && (x_in == '0);
  assign slot_sel = y_in[Y_W-1:3];
  assign reg_sel  = y_in[2:0];

  // Slot register file; slots beyond NUM_RECTS simply match no index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x_q[i] <= '0;  sh_y_q[i] <= '0;  sh_w_q[i] <= '0;  sh_h_q[i] <= '0;
        sh_col_q[i] <= '1; sh_ctl_q[i] <= '0;
        ac_x_q[i] <= '0;  ac_y_q[i] <= '0;  ac_w_q[i] <= '0;  ac_h_q[i] <= '0;
        ac_col_q[i] <= '1; ac_ctl_q[i] <= '0;
      end
    end else if (claim) begin
      if (reg_sel == 3'd7) begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          ac_x_q[i] <= sh_x_q[i];  ac_y_q[i] <= sh_y_q[i];
          ac_w_q[i] <= sh_w_q[i];  ac_h_q[i] <= sh_h_q[i];
          ac_col_q[i] <= sh_col_q[i]; ac_ctl_q[i] <= sh_ctl_q[i];
        end
      end else begin
        for (int i = 0; i < NUM_RECTS; i++) begin
          if (slot_sel == SLOT_W'(i)) begin
            case (reg_sel)
              3'd0: sh_x_q[i]   <= data_ext[X_W-1:0];
              3'd1: sh_y_q[i]   <= data_ext[Y_W-1:0];
              3'd2: sh_w_q[i]   <= data_ext[X_W-1:0];
              3'd3: sh_h_q[i]   <= data_ext[Y_W-1:0];
              3'd4: sh_col_q[i] <= data_in;
              3'd5: sh_ctl_q[i] <= data_in[1:0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // One extra bit on every coordinate so x+w and y+h never wrap.
  function automatic logic hit_fn(
    input logic [X_W-1:0] px, input logic [Y_W-1:0] py,
    input logic [X_W-1:0] rx, input logic [Y_W-1:0] ry,
    input logic [X_W-1:0] rw, input logic [Y_W-1:0] rh,
    input logic [1:0]     ctl
  );
    logic [X_W:0] xe, x0, x1;
    logic [Y_W:0] ye, y0, y1;
    logic         fill, near_edge;
    xe = {1'b0, px};
    x0 = {1'b0, rx};
    x1 = x0 + {1'b0, rw};
    ye = {1'b0, py};
    y0 = {1'b0, ry};
    y1 = y0 + {1'b0, rh};
    fill = ctl[0] && (xe >= x0) && (xe < x1) && (ye >= y0) && (ye < y1);
    near_edge = ((xe - x0) < BX) || ((x1 - (X_W+1)'(1) - xe) < BX) ||
                ((ye - y0) < BY) || ((y1 - (Y_W+1)'(1) - ye) < BY);
    return fill && (!ctl[1] || near_edge);
  endfunction

  logic [NUM_RECTS-1:0] hit_d;
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit_d[i] = !program_in && hit_fn(x_in, y_in, ac_x_q[i], ac_y_q[i],
                                       ac_w_q[i], ac_h_q[i], ac_ctl_q[i]);
    end
  end

  logic                 p1_q;
  logic [X_W-1:0]       x1_q;
  logic [Y_W-1:0]       y1_q;
  logic [COL_W-1:0]     d1_q;
  logic [NUM_RECTS-1:0] hit1_q;
  logic [COL_W-1:0]     col1_q [NUM_RECTS];
  logic [COL_W-1:0]     sel_col;

  // Colours are captured alongside the hit vector so a commit landing between
  // the two stages cannot pair old geometry with a new colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      d1_q   <= '0;
      hit1_q <= '0;
      for (int i = 0; i < NUM_RECTS; i++) col1_q[i] <= '0;
    end else begin
      p1_q   <= program_in;
      x1_q   <= program_in ? (x_in - X_W'(1)) : x_in;
      y1_q   <= y_in;
      d1_q   <= data_in;
      hit1_q <= hit_d;
      for (int i = 0; i < NUM_RECTS; i++) col1_q[i] <= ac_col_q[i];
    end
  end

  always_comb begin
    sel_col = d1_q;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit1_q[i]) sel_col = col1_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      program_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      data_out    <= '0;
    end else begin
      program_out <= p1_q;
      x_out       <= x1_q;
      y_out       <= y1_q;
      data_out    <= sel_col;
    end
  end

endmodule

// File: tb/tb_rect_renderer_multi.sv
// Directed self-checking bench for rect_renderer_multi with default parameters.
module tb_rect_renderer_multi;

  logic        clk;
  logic        rst;
  logic        program_in;
  logic [10:0] x_in;
  logic [11:0] y_in;
  logic [11:0] data_in;
  logic        program_out;
  logic [10:0] x_out;
  logic [11:0] y_out;
  logic [11:0] data_out;

  int checks;
  int failures;

  rect_renderer_multi dut (
    .clk(clk), .rst(rst),
    .program_in(program_in), .x_in(x_in), .y_in(y_in), .data_in(data_in),
    .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One word in, idle after it, return 1 time unit after its output edge.
  task automatic drive_word(input logic p, input logic [10:0] x,
                            input logic [11:0] y, input logic [11:0] d);
    @(negedge clk);
    program_in = p; x_in = x; y_in = y; data_in = d;
    @(posedge clk);
    @(negedge clk);
    program_in = 1'b0; x_in = '0; y_in = '0; data_in = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int slot, input int r, input logic [11:0] v);
    drive_word(1'b1, 11'd0, 12'(slot * 8 + r), v);
  endtask

  task automatic commit(input logic [11:0] y);
    drive_word(1'b1, 11'd0, y, 12'h000);
  endtask

  task automatic set_rect(input int slot, input int x, input int y, input int w,
                          input int h, input logic [11:0] col, input logic [11:0] ctl);
    write_reg(slot, 0, 12'(x));
    write_reg(slot, 1, 12'(y));
    write_reg(slot, 2, 12'(w));
    write_reg(slot, 3, 12'(h));
    write_reg(slot, 4, col);
    write_reg(slot, 5, ctl);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    program_in = 1'b1; x_in = 11'd0; y_in = 12'd4; data_in = 12'h0AA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({program_out, x_out, y_out, data_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got p=%0b x=%h y=%h d=%h expected all zero",
               program_out, x_out, y_out, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    program_in = 1'b0; x_in = 11'd5; y_in = 12'd5; data_in = 12'h123;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 12'h000 || program_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_cycle got d=%h p=%0b expected 000 0", data_out, program_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 12'h123 || x_out !== 11'd5 || y_out !== 12'd5 || program_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_pixel got d=%h x=%0d y=%0d p=%0b expected 123 5 5 0",
               data_out, x_out, y_out, program_out);
    end
  endtask

  task automatic test_fill();
    logic [10:0] px [6];
    logic [11:0] py [6];
    logic [11:0] ex [6];
    px = '{11'd10, 11'd13, 11'd14, 11'd10, 11'd9, 11'd10};
    py = '{12'd20, 12'd22, 12'd20, 12'd23, 12'd20, 12'd19};
    ex = '{12'hF00, 12'hF00, 12'hABC, 12'hABC, 12'hABC, 12'hABC};
    set_rect(0, 10, 20, 4, 3, 12'hF00, 12'h001);
    commit(12'd7);
    for (int i = 0; i < 6; i++) begin
      drive_word(1'b0, px[i], py[i], 12'hABC);
      checks++;
      if (data_out !== ex[i] || x_out !== px[i] || y_out !== py[i] || program_out !== 1'b0) begin
        failures++;
        $display("FAIL fill_%0d got d=%h x=%0d y=%0d p=%0b expected d=%h x=%0d y=%0d p=0",
                 i, data_out, x_out, y_out, program_out, ex[i], px[i], py[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [10:0] px [4];
    logic [11:0] py [4];
    logic [11:0] ex [4];
    px = '{11'd12, 11'd20, 11'd21, 11'd22};
    py = '{12'd21, 12'd25, 12'd29, 12'd29};
    ex = '{12'hF00, 12'h0F0, 12'h0F0, 12'hABC};
    set_rect(1, 12, 20, 10, 10, 12'h0F0, 12'h001);
    commit(12'd7);
    for (int i = 0; i < 4; i++) begin
      drive_word(1'b0, px[i], py[i], 12'hABC);
      checks++;
      if (data_out !== ex[i]) begin
        failures++;
        $display("FAIL priority_%0d got d=%h expected %h", i, data_out, ex[i]);
      end
    end
  endtask

  task automatic test_outline();
    logic [10:0] px [8];
    logic [11:0] py [8];
    logic [11:0] ex [8];
    px = '{11'd1, 11'd8, 11'd5, 11'd5, 11'd2, 11'd7, 11'd31, 11'd34};
    py = '{12'd5, 12'd5, 12'd5, 12'd9, 12'd5, 12'd7, 12'd32, 12'd31};
    ex = '{12'h555, 12'h555, 12'hABC, 12'h555, 12'hABC, 12'hABC, 12'h777, 12'hABC};
    set_rect(2, 0, 0, 10, 10, 12'h555, 12'h003);
    set_rect(3, 30, 30, 4, 4, 12'h777, 12'h003);
    commit(12'd7);
    for (int i = 0; i < 8; i++) begin
      drive_word(1'b0, px[i], py[i], 12'hABC);
      checks++;
      if (data_out !== ex[i]) begin
        failures++;
        $display("FAIL outline_%0d got d=%h expected %h", i, data_out, ex[i]);
      end
    end
  endtask

  task automatic test_shadow_commit();
    write_reg(0, 4, 12'h00F);
    drive_word(1'b0, 11'd10, 12'd20, 12'hABC);
    checks++;
    if (data_out !== 12'hF00) begin
      failures++;
      $display("FAIL shadow_before_commit got d=%h expected F00", data_out);
    end
    commit(12'd31);
    drive_word(1'b0, 11'd10, 12'd20, 12'hABC);
    checks++;
    if (data_out !== 12'h00F) begin
      failures++;
      $display("FAIL shadow_after_commit got d=%h expected 00F", data_out);
    end
  endtask

  task automatic test_program_pass();
    drive_word(1'b1, 11'd3, 12'd4, 12'h5A5);
    checks++;
    if (program_out !== 1'b1 || x_out !== 11'd2 || y_out !== 12'd4 || data_out !== 12'h5A5) begin
      failures++;
      $display("FAIL pass_hop got p=%0b x=%h y=%h d=%h expected 1 002 004 5A5",
               program_out, x_out, y_out, data_out);
    end
    drive_word(1'b1, 11'd0, 12'd36, 12'h111);
    checks++;
    if (program_out !== 1'b1 || x_out !== 11'h7FF || y_out !== 12'd36 || data_out !== 12'h111) begin
      failures++;
      $display("FAIL pass_claimed got p=%0b x=%h y=%h d=%h expected 1 7FF 024 111",
               program_out, x_out, y_out, data_out);
    end
    write_reg(0, 6, 12'h000);
    commit(12'd7);
    drive_word(1'b0, 11'd10, 12'd20, 12'hABC);
    checks++;
    if (data_out !== 12'h00F) begin
      failures++;
      $display("FAIL pass_no_state_change got d=%h expected 00F", data_out);
    end
  endtask

  task automatic test_wrap_edge();
    logic [10:0] px [3];
    logic [11:0] py [3];
    logic [11:0] ex [3];
    px = '{11'd2047, 11'd2046, 11'd2047};
    py = '{12'd100, 12'd100, 12'd101};
    ex = '{12'h333, 12'hABC, 12'hABC};
    set_rect(3, 2047, 100, 1, 1, 12'h333, 12'h001);
    commit(12'd7);
    for (int i = 0; i < 3; i++) begin
      drive_word(1'b0, px[i], py[i], 12'hABC);
      checks++;
      if (data_out !== ex[i] || x_out !== px[i]) begin
        failures++;
        $display("FAIL wrap_%0d got d=%h x=%h expected d=%h x=%h", i, data_out, x_out, ex[i], px[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] px [5];
    logic [11:0] py [5];
    logic [11:0] pd [5];
    logic [11:0] ex [5];
    px = '{11'd10, 11'd14, 11'd25, 11'd5, 11'd20};
    py = '{12'd20, 12'd20, 12'd25, 12'd5, 12'd25};
    pd = '{12'h101, 12'h202, 12'h303, 12'h404, 12'h505};
    ex = '{12'h00F, 12'h0F0, 12'h303, 12'h404, 12'h0F0};
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        checks++;
        if (data_out !== ex[t-2] || x_out !== px[t-2] || y_out !== py[t-2] || program_out !== 1'b0) begin
          failures++;
          $display("FAIL b2b_%0d got d=%h x=%0d y=%0d expected d=%h x=%0d y=%0d",
                   t - 2, data_out, x_out, y_out, ex[t-2], px[t-2], py[t-2]);
        end
      end
      if (t < 5) begin
        program_in = 1'b0; x_in = px[t]; y_in = py[t]; data_in = pd[t];
      end else begin
        program_in = 1'b0; x_in = '0; y_in = '0; data_in = '0;
      end
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    program_in = 1'b0; x_in = 11'd10; y_in = 12'd20; data_in = 12'h999;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 12'h000 || x_out !== 11'd0 || y_out !== 12'd0) begin
      failures++;
      $display("FAIL midreset_flush got d=%h x=%h y=%h expected 000 000 000", data_out, x_out, y_out);
    end
    @(negedge clk);
    rst = 1'b0;
    data_in = 12'h246;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 12'h000) begin
      failures++;
      $display("FAIL midreset_stage_clear got d=%h expected 000", data_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 12'h246) begin
      failures++;
      $display("FAIL midreset_active_cleared got d=%h expected 246", data_out);
    end
    commit(12'd7);
    drive_word(1'b0, 11'd10, 12'd20, 12'h246);
    checks++;
    if (data_out !== 12'h246) begin
      failures++;
      $display("FAIL midreset_shadow_cleared got d=%h expected 246", data_out);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    program_in = 1'b0; x_in = '0; y_in = '0; data_in = '0;
    test_reset();
    test_fill();
    test_priority();
    test_outline();
    test_shadow_commit();
    test_program_pass();
    test_wrap_edge();
    test_back_to_back();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_renderer_multi.md
Name: rect_renderer_multi

Overview:
- Parametrised successor to the single-rectangle renderer; sits in the same daisy-chained pixel stream (x, y, data, program) between the pixel source and the display sink.
- Holds NUM_RECTS rectangle slots, each with a fill/outline mode and enable.
- Uses shadow/active double-buffered registers with an explicit commit, so reprogramming never tears a frame.
- Fixed 2-cycle pipeline for all words, pixel and program alike.

Parameters:
- X_W, 11, x coordinate width (bits)
- Y_W, 12, y coordinate width (bits); also the programming address width
- COL_W, 12, colour/data width (bits)
- NUM_RECTS, 4, number of rectangle slots (1..2^(Y_W-3))
- BORDER, 2, outline thickness in pixels (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- program_in  in  1  current word is a programming word
- x_in  in  X_W  pixel x / chain hop counter when programming
- y_in  in  Y_W  pixel y / register address when programming
- data_in  in  COL_W  upstream pixel colour / programming data
- program_out  out  1  program_in delayed 2 cycles
- x_out  out  X_W  x delayed 2 cycles; decremented if programming
- y_out  out  Y_W  y_in delayed 2 cycles
- data_out  out  COL_W  resulting pixel colour / forwarded programming data

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs become 0; pipeline stages cleared.
  - Every slot, shadow and active: x=0, y=0, w=0, h=0, colour=all ones, ctrl=0 (disabled, fill).
  - Reset wins over any simultaneous program write.
- Addressing: a word is claimed by this block when program_in=1 and x_in==0.
  - slot = y_in[Y_W-1:3]; reg = y_in[2:0].
  - reg 0: x (low X_W bits of data_in).
  - reg 1: y (low Y_W bits, zero-extended if COL_W<Y_W).
  - reg 2: width.
  - reg 3: height.
  - reg 4: colour.
  - reg 5: ctrl; bit0 = enable, bit1 = outline mode.
  - reg 7: commit. Copies all shadow slots to active in one edge; slot bits are ignored.
  - reg 6, and any slot >= NUM_RECTS: ignored, no state change.
- Write timing: a shadow write takes effect at the edge that samples the word. Commit makes active registers change at that same edge.
  - A pixel sampled on the next edge sees the new active values.
  - Shadow write and commit are never in the same word, so they cannot collide.
- Program pass-through: every program word, claimed or not, exits 2 cycles later.
  - program_out=1, data_out=data_in, y_out=y_in.
  - x_out = x_in-1 modulo 2^X_W, so a claimed word leaves with x=all ones.
- Pixel path (program_in=0):
  - Stage 1 registers a hit vector per slot.
  - Stage 2 selects the colour of the lowest-index hit slot; if there is no hit, data_out=data_in unchanged.
  - x_out=x_in and y_out=y_in, both delayed 2 cycles.
- Hit rules:
  - All comparisons use X_W+1 / Y_W+1 bits, so x+w and y+h never wrap.
  - Fill: enable && x_in>=x && x_in<x+w && y_in>=y && y_in<y+h.
  - Outline: fill hit && (x_in-x<BORDER || x+w-1-x_in<BORDER || y_in-y<BORDER || y+h-1-y_in<BORDER).
  - w<=2*BORDER or h<=2*BORDER therefore renders as solid.
  - w=0 or h=0 never hits.
- Throughput: one word per cycle, no stalls, no backpressure. Latency is exactly 2 cycles for every word.
- Reset mid-stream: in-flight words are discarded and outputs read 0 the cycle after reset is released. The first valid word appears 2 cycles after it enters.

Test Plan:
- Reset then stream pixel (5,5,data 0x123) -> 2 cycles later data_out=0x123, x_out=5, y_out=5, program_out=0.
- Program slot0: x=10, y=20, w=4, h=3, colour 0xF00, ctrl=1, then commit (y=7). Pixel (10,20) -> 0xF00. (13,22) -> 0xF00. (14,20) -> data_in. (10,23) -> data_in.
- Slot0 as above. Slot1: x=12, y=20, w=10, h=10, colour 0x0F0, enabled. Commit. Pixel (12,21) -> 0xF00 (priority). (20,25) -> 0x0F0.
- Slot2: x=0, y=0, w=10, h=10, ctrl=3 (outline). BORDER=2. Commit. (1,5) -> colour. (8,5) -> colour. (5,5) -> data_in. (5,9) -> colour.
- Write slot0 colour 0x00F without commit -> pixel (10,20) still 0xF00. After commit (y=7) -> 0x00F.
- Program word x_in=3, y_in=4 -> x_out=2, no state change. x_in=0, slot>=NUM_RECTS -> ignored, x_out=all ones. Edge case x_in=2^X_W-1, w=1 hits with no wrap.
